// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline register file and its users
// (decode, writeback). Holds the architectural zero register index, the
// default register file geometry and the register address type.
// ---------------------------------------------------------------------------
package mips_pkg;

    // Architectural hard-wired zero register.
    localparam int REG_ZERO  = 0;

    // Default register file geometry.
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_AW    = $clog2(DEF_DEPTH);

    // Register address as carried through decode and writeback.
    typedef logic [DEF_AW-1:0] reg_addr_t;

endpackage : mips_pkg

// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if
// Bundle of the register file read, writeback and issue-allocation signals.
//   ra          read addresses, port i at [i*AW +: AW]
//   rd          read data, port i at [i*WIDTH +: WIDTH]
//   rd_busy     per-port "operand still pending" flag
//   we/wa/wd    writeback strobe, address, data
//   alloc       issue request marking a new pending write to alloc_addr
//   alloc_ready issue may proceed this cycle
//   err         sticky "writeback without pending allocation" flag
// master: pipeline side (drives addresses/strobes); slave: register file.
// ---------------------------------------------------------------------------
interface regfile_sb_if
    import mips_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int NRD   = 2
) ();

    logic [NRD*AW-1:0]    ra;
    logic [NRD*WIDTH-1:0] rd;
    logic [NRD-1:0]       rd_busy;
    logic                 we;
    logic [AW-1:0]        wa;
    logic [WIDTH-1:0]     wd;
    logic                 alloc;
    logic [AW-1:0]        alloc_addr;
    logic                 alloc_ready;
    logic                 err;

    modport master (
        output ra, we, wa, wd, alloc, alloc_addr,
        input  rd, rd_busy, alloc_ready, err
    );

    modport slave (
        input  ra, we, wa, wd, alloc, alloc_addr,
        output rd, rd_busy, alloc_ready, err
    );

endinterface : regfile_sb_if

// File: rtl/regfile_sb_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Per-register pending-write counters for the register file.
//   clk, rst        clock, asynchronous active-high reset
//   ra_i            read addresses of all NRD ports
//   we_i, wa_i      writeback strobe and address (retires one pending write)
//   alloc_i         issue request, alloc_addr_i its destination register
//   alloc_ready_o   combinational: allocation can be accepted this cycle
//   rd_busy_o       combinational: port operand still pending after this
//                   cycle's writeback
//   err_o           sticky: writeback hit a register with no pending write
// ---------------------------------------------------------------------------
module reg_scoreboard
    import mips_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int NRD   = 2,
    parameter int PCW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] ra_i,
    input  logic              we_i,
    input  logic [AW-1:0]     wa_i,
    input  logic              alloc_i,
    input  logic [AW-1:0]     alloc_addr_i,
    output logic              alloc_ready_o,
    output logic [NRD-1:0]    rd_busy_o,
    output logic              err_o
);

    localparam logic [PCW-1:0] CNT_MAX = '1;

    logic [PCW-1:0] cnt_q [DEPTH];
    logic [PCW-1:0] cnt_d [DEPTH];
    logic           err_q;
    logic           err_d;

    logic           wb_live;
    logic           alloc_ok;

    // Writes to the zero register neither retire counts nor raise err.
    assign wb_live = we_i && (wa_i != AW'(REG_ZERO));

    // A saturated counter can still accept an alloc when the same cycle's
    // writeback retires one entry, since the net change is zero.
    assign alloc_ready_o = (alloc_addr_i == AW'(REG_ZERO)) ||
                           !((cnt_q[alloc_addr_i] == CNT_MAX) &&
                             !(we_i && (wa_i == alloc_addr_i)));

    assign alloc_ok = alloc_i && alloc_ready_o &&
                      (alloc_addr_i != AW'(REG_ZERO));

    always_comb begin
        // NOTE: every target gets a default before any conditional update so
        // no path leaves it unassigned and no latch is inferred.
        for (int r = 0; r < DEPTH; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        cnt_d[0] = '0;
        for (int r = 1; r < DEPTH; r++) begin
            cnt_d[r] = cnt_q[r]
                     + PCW'(alloc_ok && (alloc_addr_i == AW'(r)))
                     - PCW'(wb_live && (wa_i == AW'(r)) && (cnt_q[r] != '0));
        end
        err_d = err_q | (wb_live && (cnt_q[wa_i] == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counter array is reset entry by entry; a reset-less
            // array would leave stale pending counts after a pipeline flush.
            for (int r = 0; r < DEPTH; r++) begin
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every flop samples the pre-edge values of its inputs.
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Busy means the count remains non-zero after this cycle's retire.
    // A retire only happens when the count is non-zero, so "cnt > dec"
    // equals "cnt - dec != 0".
    always_comb begin
        rd_busy_o = '0;
        for (int i = 0; i < NRD; i++) begin
            if (ra_i[i*AW +: AW] != AW'(REG_ZERO)) begin
                rd_busy_o[i] = cnt_q[ra_i[i*AW +: AW]] >
                               PCW'(we_i && (wa_i == ra_i[i*AW +: AW]));
            end
        end
    end

    assign err_o = err_q;

endmodule : reg_scoreboard

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// General-purpose register file with NRD combinational read ports,
// write-through bypass and a pending-write scoreboard.
//   clk  clock, all state updates on the rising edge
//   rst  asynchronous active-high reset; clears data, counters and err
//   bus  regfile_sb_if slave: read ports, writeback, issue allocation,
//        busy/ready/err status
// Storage is a flop array so reset clears every register.
// ---------------------------------------------------------------------------
module regfile_sb
    import mips_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int NRD   = 2,
    parameter int PCW   = 2
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);

    logic [WIDTH-1:0]     ram_q [DEPTH];
    logic [NRD*WIDTH-1:0] rd_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                ram_q[r] <= '0;
            end
        end else if (bus.we && (bus.wa != AW'(REG_ZERO))) begin
            ram_q[bus.wa] <= bus.wd;
        end
    end

    // Read mux: zero register, then same-cycle writeback bypass, then
    // storage. Bypass is blocked during reset so reads stay 0 even if the
    // pipeline is still presenting a writeback.
    always_comb begin
        rd_c = '0;
        for (int i = 0; i < NRD; i++) begin
            if (bus.ra[i*AW +: AW] == AW'(REG_ZERO)) begin
                rd_c[i*WIDTH +: WIDTH] = '0;
            end else if (!rst && bus.we && (bus.wa == bus.ra[i*AW +: AW])) begin
                rd_c[i*WIDTH +: WIDTH] = bus.wd;
            end else begin
                rd_c[i*WIDTH +: WIDTH] = ram_q[bus.ra[i*AW +: AW]];
            end
        end
    end

    assign bus.rd = rd_c;

    reg_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .NRD   (NRD),
        .PCW   (PCW)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .ra_i          (bus.ra),
        .we_i          (bus.we),
        .wa_i          (bus.wa),
        .alloc_i       (bus.alloc),
        .alloc_addr_i  (bus.alloc_addr),
        .alloc_ready_o (bus.alloc_ready),
        .rd_busy_o     (bus.rd_busy),
        .err_o         (bus.err)
    );

endmodule : regfile_sb

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the MIPS pipeline with N combinational read ports, write-through bypass and a per-register pending-write scoreboard. It replaces the plain two-read/one-write register file in the decode stage. Decode allocates destination registers at issue, writeback retires them, and the read ports report whether each operand is still pending so hazard logic can stall.

## Interface
Parameters:
- `WIDTH`, 32, data width of each register.
- `DEPTH`, 32, number of registers. Power of two, at least 2.
- `AW`, `$clog2(DEPTH)`, register address width.
- `NRD`, 2, number of read ports (1..4).
- `PCW`, 2, width of the per-register pending counter. Maximum in-flight writes per register is 2^PCW-1.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst`  in  1  Asynchronous reset, active-high.
- `ra`  in  NRD*AW  Read addresses; port i is bits [i*AW +: AW].
- `rd`  out  NRD*WIDTH  Read data, combinational.
- `rd_busy`  out  NRD  Port i operand still pending after this cycle's writeback.
- `we`  in  1  Writeback strobe; performs the write and retires one pending write.
- `wa`  in  AW  Writeback address.
- `wd`  in  WIDTH  Writeback data.
- `alloc`  in  1  Issue request; marks one new pending write to `alloc_addr`.
- `alloc_addr`  in  AW  Destination register of the issuing instruction.
- `alloc_ready`  out  1  Combinational; 0 when `alloc_addr`'s counter is saturated and the cycle's `we` does not retire it.
- `err`  out  1  Sticky flag: writeback to a register whose counter was 0. Cleared only by `rst`.

## Operation
- **Register 0**
  - Reads return 0 and are never busy.
  - Writes are ignored, and allocs to it are ignored; `alloc_ready` is 1 for address 0.
  - `err` is never set by `we` with `wa`=0.
- **Read path**
  - `rd[i]` = `wd` when `we` && `wa`==`ra[i]` && `ra[i]`!=0 (bypass).
  - Otherwise `rd[i]` = RAM[`ra[i]`].
  - All ports are independent; any number may hit the same address.
- **Write**
  - On the edge with `we` && `wa`!=0: RAM[`wa`] <= `wd`.
- **Scoreboard**
  - Each register r has a counter cnt[r] of width PCW. Per edge, for r != 0:
    - inc = `alloc` && `alloc_ready` && `alloc_addr`==r.
    - dec = `we` && `wa`==r && cnt[r]!=0.
    - cnt[r] <= cnt[r] + inc - dec.
  - Alloc and writeback to the same register in the same cycle leave cnt unchanged.
  - `alloc` while `alloc_ready`=0 is dropped: no count change. Issue logic must hold the instruction.
  - `alloc_ready` = !(cnt[alloc_addr]==max && !(`we` && `wa`==`alloc_addr`)).
- **Busy**
  - `rd_busy[i]` = cnt[ra[i]] - (`we` && `wa`==ra[i] && cnt!=0) != 0.
  - A single pending write that completes this cycle therefore reads as not busy, with bypassed data.
- **Error**
  - `we` with `wa`!=0 and cnt[`wa`]==0: the write is still performed, cnt stays 0, and `err` <= 1.

## Timing
- Reads, `rd_busy` and `alloc_ready` are combinational: 0-cycle latency.
- RAM, counters and `err` update on the rising edge of `clk`. A write is visible through RAM one cycle after `we`, and through bypass in the same cycle.
- **Reset values**
  - `rst` asserted clears all RAM entries to 0, all cnt to 0 and `err` to 0, immediately and independent of `clk`.
  - While `rst` is high: `rd`=0, `rd_busy`=0, `alloc_ready`=1, `err`=0.
  - Writes and allocs during reset are discarded.
- **Reset mid-operation**
  - All pending writes are forgotten.
  - A writeback arriving after reset release to a zero counter sets `err`. The pipeline must flush together with this block.

## Structure
- A shared package `mips_pkg` holds:
  - `REG_ZERO`=0.
  - Default `WIDTH`/`DEPTH` constants.
  - A `reg_addr_t` typedef used by decode and writeback.
- The natural sub-module is `reg_scoreboard`: the counter array, `alloc_ready`, `rd_busy` and `err`. It is instantiated once inside `regfile_sb`; data storage and bypass stay in the top level.
- `regfile_sb` must not infer reset-less RAM. Reset must clear all registers, so storage is flops.

## Test plan
- **Reset:** assert `rst` mid-run with stored values → all `ra` read 0, `rd_busy`=0, `err`=0; after release, write 0x1234 to r5 → next cycle `rd[0]` with `ra`=5 returns 0x1234.
- **Register 0 and bypass:** `we`, `wa`=0, `wd`=0xFFFFFFFF → `rd` for `ra`=0 stays 0. `we`, `wa`=7, `wd`=0xA5A5A5A5 with `ra[1]`=7 in the same cycle → `rd[1]`=0xA5A5A5A5 combinationally.
- **Scoreboard:** alloc r3 twice → `rd_busy`=1 for r3. Writeback r3 once → still busy. Second writeback → `rd_busy`=0 in that cycle, with bypass data.
- **Saturation with PCW=2:**
  - Three allocs to r9 → `alloc_ready`=0 and a fourth alloc leaves cnt=3.
  - Alloc plus `we` to r9 in the same cycle → `alloc_ready`=1 and cnt stays 3.
- **Error:** `we` to r12 with cnt=0, `wd`=0x55 → RAM[12]=0x55 and `err`=1, which stays 1 until `rst`.
- **Multi-port with NRD=4:** all four ports on r4 while r4 is being written back → all return `wd`, all `rd_busy`=0.
